// File: rtl/restoring_divider_pkg.sv
// divider_pkg: state encoding, default width and counter sizing shared by the divider files.
package divider_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
    localparam int DEFAULT_WIDTH = 4;
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction
    localparam int CNT_W = cnt_width(DEFAULT_WIDTH);
endpackage

// File: rtl/restoring_divider_if.sv
// restoring_divider_if: start/busy/done handshake plus operand and result buses.
interface restoring_divider_if #(
    parameter int WIDTH = divider_pkg::DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );
    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/restoring_divider_ripple_subtractor.sv
// ripple_subtractor: combinational N-bit a-b from full-subtractor cells chained on borrow.
module ripple_subtractor #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         bout
);
    logic [N:0] br;
    assign br[0] = 1'b0;
    for (genvar i = 0; i < N; i++) begin : g_cell
        assign diff[i]  = a[i] ^ b[i] ^ br[i];
        assign br[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
    end
    assign bout = br[N];
endmodule

// File: rtl/restoring_divider.sv
// restoring_divider: sequential unsigned divider, one quotient bit per clock.
// Define DIV_EARLY_DONE_EN to finish in one cycle when divisor > dividend.
module restoring_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic clk,
    input logic rst,
    restoring_divider_if.slave bus
);
    localparam int CW = cnt_width(WIDTH);
    state_t state, state_next;
    logic [WIDTH-1:0] q, d, quo, rem;
    logic [WIDTH:0] r, r_sh, diff, r_next;
    logic [CW-1:0] cnt;
    logic bout, done_r, dbz, accept, last, early, fin;

    assign r_sh = (r << 1) | (WIDTH + 1)'(q[WIDTH-1]);

    ripple_subtractor #(.N(WIDTH + 1)) u_sub (
        .a(r_sh),
        .b({1'b0, d}),
        .diff(diff),
        .bout(bout)
    );

    always_ff @(posedge clk) state <= rst ? IDLE : state_next;

    always_comb begin
        accept = bus.start && state != RUN;
        last = cnt == CW'(WIDTH - 1);
`ifdef DIV_EARLY_DONE_EN
        early = cnt == '0 && d > q;
`else
        early = 1'b0;
`endif
        fin = d == '0 || early || last;
        r_next = bout ? r_sh : diff;
        state_next = accept ? RUN : (state == RUN && fin) ? DONE : state;
    end

    // q still holds the untouched dividend on the first step, so the short-cut paths read it directly
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
            r <= '0;
            d <= '0;
            cnt <= '0;
            quo <= '0;
            rem <= '0;
            dbz <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (accept) begin
                q <= bus.dividend;
                r <= '0;
                d <= bus.divisor;
                cnt <= '0;
                dbz <= 1'b0;
            end else if (state == RUN) begin
                if (d == '0) begin
                    quo <= '1;
                    rem <= q;
                    dbz <= 1'b1;
                    done_r <= 1'b1;
                end else if (early) begin
                    quo <= '0;
                    rem <= q;
                    done_r <= 1'b1;
                end else begin
                    q <= {q[WIDTH-2:0], ~bout};
                    r <= r_next;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        quo <= {q[WIDTH-2:0], ~bout};
                        rem <= r_next[WIDTH-1:0];
                        done_r <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        bus.busy = state == RUN;
        bus.done = done_r;
        bus.quotient = quo;
        bus.remainder = rem;
        bus.div_by_zero = dbz;
    end
endmodule

// File: tb/tb_restoring_divider.sv
// tb_restoring_divider: directed, exhaustive and random checks against an arithmetic reference model.
module tb_restoring_divider;
    localparam int W = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_fail = 0;

    restoring_divider_if #(.WIDTH(W)) bus ();
    restoring_divider #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = a;
        bus.divisor = b;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_accept", bus.busy, 1);
    endtask

    task automatic finish_div(input logic [W-1:0] a, input logic [W-1:0] b, input int n0);
        int n, el, iv;
        logic [W-1:0] eq, er;
        n = n0;
        eq = (b == 0) ? {W{1'b1}} : a / b;
        er = (b == 0) ? a : a % b;
        el = (b == 0) ? 1 : W;
`ifdef DIV_EARLY_DONE_EN
        if (b != 0 && b > a) el = 1;
`endif
        while (!bus.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, el);
        chk("quotient", bus.quotient, eq);
        chk("remainder", bus.remainder, er);
        chk("div_by_zero", bus.div_by_zero, b == 0);
        chk("busy_at_done", bus.busy, 0);
        if (b != 0) begin
            iv = int'(bus.quotient) * int'(b) + int'(bus.remainder);
            chk("invariant", iv, a);
        end
    endtask

    task automatic settle(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] eq;
        eq = (b == 0) ? {W{1'b1}} : a / b;
        @(negedge clk);
        chk("done_pulse", bus.done, 0);
        chk("hold_q", bus.quotient, eq);
    endtask

    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b);
        launch(a, b);
        finish_div(a, b, 0);
        settle(a, b);
    endtask

    initial begin
        int highs;
        logic [W-1:0] a, b;
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_q", bus.quotient, 0);
        chk("rst_r", bus.remainder, 0);
        chk("rst_dbz", bus.div_by_zero, 0);
        rst = 1'b0;

        run_div(4'd13, 4'd3);

        launch(4'd15, 4'd1);
        finish_div(4'd15, 4'd1, 0);
        bus.start = 1'b1;
        bus.dividend = 4'd15;
        bus.divisor = 4'd15;
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b_done_fall", bus.done, 0);
        chk("b2b_busy", bus.busy, 1);
        finish_div(4'd15, 4'd15, 0);
        settle(4'd15, 4'd15);

        run_div(4'd9, 4'd0);
        run_div(4'd6, 4'd2);
        run_div(4'd5, 4'd7);

        launch(4'd12, 4'd5);
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = 4'd3;
        bus.divisor = 4'd1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_ignored", bus.busy, 1);
        finish_div(4'd12, 4'd5, 2);
        settle(4'd12, 4'd5);

        launch(4'd14, 4'd4);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_q", bus.quotient, 0);
        chk("midrst_r", bus.remainder, 0);
        chk("midrst_dbz", bus.div_by_zero, 0);
        highs = 0;
        repeat (6) begin
            @(negedge clk);
            highs += int'(bus.done);
        end
        chk("midrst_no_done", highs, 0);
        run_div(4'd14, 4'd4);

        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                run_div(W'(i), W'(j));

        repeat (60) begin
            a = W'($urandom);
            b = W'($urandom_range(0, 15));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_div(a, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
